order_no_allocator: RTL
=======================

# order_no_allocator

Round-robin allocator that shares the single order-number counter among N_REQ requesters (kiosks, order terminals). A requester raises `req`; the allocator grants one requester at a time, captures the current 5-character ASCII order number, pulses the counter's `enable` once to advance it, and returns the captured number with a one-cycle `ack`. It sits between the requesters and `order_no_counter`, and is the only driver of that counter's `enable`.

## Interface
- `N_REQ`, default 4: number of requesters, 2..8.
- `ID_W`, default 2: width of `alloc_id`; must equal ceil(log2(N_REQ)).

Ports:
- `clk`  in  1  single clock; all logic is on its rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `req`  in  N_REQ  level request per requester; held until own `ack`.
- `order_no_0`..`order_no_4`  in  8 each  ASCII digits from the counter; `_0` is least significant. Values are '0'-'9' (0x30-0x39) and 'A'-'Z' (0x41-0x5A).
- `cnt_enable`  out  1  advance pulse to the counter's `enable`.
- `ack`  out  N_REQ  one-hot, one-cycle grant-complete pulse.
- `alloc_valid`  out  1  high with `ack`; `alloc_no_*` and `alloc_id` are valid.
- `alloc_id`  out  ID_W  index of the acknowledged requester.
- `alloc_no_0`..`alloc_no_4`  out  8 each  captured order number.
- `busy`  out  1  state != IDLE.

## Operation
- FSM states are IDLE, ISSUE, DONE.
  - IDLE: if `req` != 0 (and not paused), latch the round-robin winner into `win_id`, then go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: `cnt_enable` = 1. At the end of the cycle, `alloc_no_*` <= `order_no_*` (the pre-increment value), `alloc_id` <= `win_id`, and the FSM goes to DONE.
  - DONE: `ack[win_id]` = 1 and `alloc_valid` = 1 (both registered), then go to IDLE.
- Round robin:
  - `last_id` updates to `win_id` on entry to ISSUE.
  - The search order is `last_id`+1, `last_id`+2, … modulo N_REQ.
  - `last_id` resets to N_REQ-1, so requester 0 has first priority after reset.
- Requester rule: deassert `req` on the clock edge that ends the `ack` cycle. The allocator never samples `req` during ISSUE or DONE.
- Changes to `req` during ISSUE/DONE are ignored; the winner is fixed at IDLE.
- `cnt_enable` = (state == ISSUE) && `rst_n`. It never asserts during reset.
- Exactly one `cnt_enable` pulse per `ack`. Every issued number is unique until the counter wraps.
- Counter wrap ("ZZZZZ" -> "00000") is transparent: "ZZZZZ" is issued normally and the next grant receives "00000".
- Reset values: state = IDLE, `cnt_enable` = 0, `ack` = 0, `alloc_valid` = 0, `alloc_id` = 0, `alloc_no_*` = 0x30, `busy` = 0, `last_id` = N_REQ-1.
- Reset asserted in ISSUE or DONE: the grant is abandoned, no `ack` is issued, and the FSM returns to IDLE. The counter shares `rst_n` and also returns to "00000".

## Timing
- Request latency: `req` first seen in IDLE at cycle T; ISSUE at T+1; `ack`/`alloc_valid` at T+2.
- Throughput: one allocation per 3 cycles under continuous demand.
- The counter output reflects an increment one cycle after `cnt_enable`. The next capture happens at least 2 cycles later, so it always sees the new value.
- `alloc_no_*` and `alloc_id` hold their value after DONE until the next ISSUE.

## Configuration
- Macro: `ORDER_NO_ALLOC_PAUSE_EN`.
- Defined: adds input `pause` (1 bit).
  - While `pause` = 1 in IDLE, no winner is selected and `req` stays pending.
  - A grant already past IDLE completes normally.
- Undefined: no `pause` port; IDLE grants whenever `req` != 0.

## Test plan
- Reset, then `req` = 4'b0001 at cycle 0 -> `cnt_enable` at cycle 1; `ack` = 4'b0001, `alloc_no_4..0` = "00000" (0x30 each), `alloc_id` = 0 at cycle 2. A second request returns "00001".
- `req` = 4'b1111 held, with each requester dropping `req` after its `ack` and re-raising it 1 cycle later -> ack order is 0, 1, 2, 3, 0. Issued numbers are "00000".."00004", with one `ack` every 3 cycles.
- Counter preloaded (via 35 grants) to "0000Z" -> that grant returns "0000Z"; the next returns "00010".
- `req` = 4'b0100 with reset asserted during ISSUE -> no `ack`. After reset release the FSM is in IDLE; a re-request gets "00000" and requester 0 has priority if it requests simultaneously.
- With `ORDER_NO_ALLOC_PAUSE_EN`: `pause` = 1 and `req` = 4'b0010 for 10 cycles -> no `cnt_enable`, no `ack`. `pause` falls at cycle 10 -> `ack[1]` at cycle 12.
- `req` changes from 4'b0001 to 4'b1000 during ISSUE -> `ack` still goes to requester 0. Requester 3 is granted next, starting from IDLE.

Source files
------------

// File: rtl/order_no_allocator.sv
// Round-robin allocator sharing one order-number counter among N_REQ requesters.
// Optional `ORDER_NO_ALLOC_PAUSE_EN adds a pause input that holds off new grants in IDLE.
module order_no_allocator #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef ORDER_NO_ALLOC_PAUSE_EN
  input  logic             pause,
`endif
  input  logic [N_REQ-1:0] req,
  input  logic [7:0]       order_no_0,
  input  logic [7:0]       order_no_1,
  input  logic [7:0]       order_no_2,
  input  logic [7:0]       order_no_3,
  input  logic [7:0]       order_no_4,
  output logic             cnt_enable,
  output logic [N_REQ-1:0] ack,
  output logic             alloc_valid,
  output logic [ID_W-1:0]  alloc_id,
  output logic [7:0]       alloc_no_0,
  output logic [7:0]       alloc_no_1,
  output logic [7:0]       alloc_no_2,
  output logic [7:0]       alloc_no_3,
  output logic [7:0]       alloc_no_4,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DONE
  } state_e;

  localparam logic [ID_W-1:0] LAST_ID_RST = ID_W'(N_REQ - 1);
  localparam logic [39:0]     ALLOC_NO_RST = {5{8'h30}};

  state_e                  state_q, state_d;
  logic [ID_W-1:0]         win_id_q, win_id_d;
  logic [ID_W-1:0]         last_id_q, last_id_d;
  logic                    cnt_enable_q, cnt_enable_d;
  logic [N_REQ-1:0]        ack_q, ack_d;
  logic                    alloc_valid_q, alloc_valid_d;
  logic [ID_W-1:0]         alloc_id_q, alloc_id_d;
  logic [4:0][7:0]         alloc_no_q, alloc_no_d;

  logic                    grant_ok;
  logic                    rr_found;
  logic [ID_W-1:0]         rr_id;
  logic [ID_W-1:0]         rr_cand;

`ifdef ORDER_NO_ALLOC_PAUSE_EN
  assign grant_ok = ~pause;
`else
  assign grant_ok = 1'b1;
`endif

  // Walk last_id+1, last_id+2, ... with explicit wrap so non-power-of-two N_REQ works.
  always_comb begin
    rr_found = 1'b0;
    rr_id    = last_id_q;
    rr_cand  = last_id_q;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      rr_cand = (rr_cand == LAST_ID_RST) ? '0 : rr_cand + ID_W'(1);
      if (!rr_found && req[rr_cand]) begin
        rr_found = 1'b1;
        rr_id    = rr_cand;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    win_id_d      = win_id_q;
    last_id_d     = last_id_q;
    cnt_enable_d  = 1'b0;
    ack_d         = '0;
    alloc_valid_d = 1'b0;
    alloc_id_d    = alloc_id_q;
    alloc_no_d    = alloc_no_q;
    case (state_q)
      IDLE: begin
        if (rr_found && grant_ok) begin
          win_id_d     = rr_id;
          last_id_d    = rr_id;
          cnt_enable_d = 1'b1;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        // Counter advances on this same edge, so the capture is the pre-increment value.
        alloc_no_d        = {order_no_4, order_no_3, order_no_2, order_no_1, order_no_0};
        alloc_id_d        = win_id_q;
        ack_d[win_id_q]   = 1'b1;
        alloc_valid_d     = 1'b1;
        state_d           = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      win_id_q      <= '0;
      last_id_q     <= LAST_ID_RST;
      cnt_enable_q  <= 1'b0;
      ack_q         <= '0;
      alloc_valid_q <= 1'b0;
      alloc_id_q    <= '0;
      alloc_no_q    <= ALLOC_NO_RST;
    end else begin
      state_q       <= state_d;
      win_id_q      <= win_id_d;
      last_id_q     <= last_id_d;
      cnt_enable_q  <= cnt_enable_d;
      ack_q         <= ack_d;
      alloc_valid_q <= alloc_valid_d;
      alloc_id_q    <= alloc_id_d;
      alloc_no_q    <= alloc_no_d;
    end
  end

  // Gating with rst_n keeps the pulse off the moment reset lands mid-ISSUE.
  assign cnt_enable  = cnt_enable_q & rst_n;
  assign ack         = ack_q;
  assign alloc_valid = alloc_valid_q;
  assign alloc_id    = alloc_id_q;
  assign alloc_no_0  = alloc_no_q[0];
  assign alloc_no_1  = alloc_no_q[1];
  assign alloc_no_2  = alloc_no_q[2];
  assign alloc_no_3  = alloc_no_q[3];
  assign alloc_no_4  = alloc_no_q[4];
  assign busy        = (state_q != IDLE);

endmodule
